// File: rtl/pfd_counter.sv
// -----------------------------------------------------------------------------
// pfd_counter -- digital phase/frequency detector that measures, in CLK cycles,
// how far the reference clock IN leads or lags the feedback clock FB.
//
// Both raw clocks are synchronised into the CLK domain and turned into
// one-cycle rising-edge strobes. A three-state FSM (IDLE / LEAD_IN / LEAD_FB)
// opens a measurement on the first strobe and closes it on the other one,
// emitting a signed, saturated cycle count on PHASE_ERR with an ERR_VALID
// strobe. Two strobes of the same clock without the other in between are a
// cycle slip: full-scale error plus a SLIP strobe.
//
// Parameters
//   WIDTH     bit width of the signed PHASE_ERR (two's complement)
//   LOCK_TOL  largest |PHASE_ERR| that counts as an in-lock measurement
//   LOCK_CNT  consecutive in-lock measurements needed to raise LOCK
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET_B    in   asynchronous active-low reset
//   IN         in   reference clock (asynchronous to CLK)
//   FB         in   feedback clock (asynchronous to CLK)
//   UP         out  high while a measurement is open with IN leading
//   DN         out  high while a measurement is open with FB leading
//   PHASE_ERR  out  signed phase error in CLK cycles, positive = IN leads
//   ERR_VALID  out  one-cycle strobe, PHASE_ERR updated this cycle
//   SLIP       out  one-cycle strobe on a cycle slip
//   LOCK       out  lock indicator
//
// Build option
//   PFD_LOCK_DET_EN  when defined, a lock detector drives LOCK; otherwise
//                    LOCK is tied low and no lock logic exists.
// -----------------------------------------------------------------------------
module pfd_counter #(
  parameter int WIDTH    = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_B,
  input  logic                    IN,
  input  logic                    FB,
  output logic                    UP,
  output logic                    DN,
  output logic signed [WIDTH-1:0] PHASE_ERR,
  output logic                    ERR_VALID,
  output logic                    SLIP,
  output logic                    LOCK
);

  localparam int CW = WIDTH - 1;
  localparam logic [CW-1:0]           CNT_MAX = {CW{1'b1}};
  // Largest magnitude ever emitted; -2^(WIDTH-1) is deliberately unreachable.
  localparam logic signed [WIDTH-1:0] ERR_MAX = {1'b0, CNT_MAX};
  localparam logic signed [WIDTH-1:0] ERR_NEG = -ERR_MAX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEAD_IN = 2'd1,
    LEAD_FB = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers, edge detectors and post-reset strobe mask
  // ---------------------------------------------------------------------------
  logic       in_meta_q, in_meta_d, in_sync_q, in_sync_d, in_prev_q, in_prev_d;
  logic       fb_meta_q, fb_meta_d, fb_sync_q, fb_sync_d, fb_prev_q, fb_prev_d;
  logic [1:0] mask_q, mask_d;
  logic       s_in_q, s_in_d, s_fb_q, s_fb_d;
  logic       mask_done;

  assign mask_done = (mask_q == 2'd3);

  always_comb begin
    in_meta_d = IN;
    in_sync_d = in_meta_q;
    in_prev_d = in_sync_q;
    fb_meta_d = FB;
    fb_sync_d = fb_meta_q;
    fb_prev_d = fb_sync_q;
    // Counts the first three CLK after reset release, then sticks; strobes
    // are suppressed until then so an input already high is not an edge.
    mask_d    = mask_done ? mask_q : mask_q + 2'd1;
    s_in_d    = in_sync_q & ~in_prev_q & mask_done;
    s_fb_d    = fb_sync_q & ~fb_prev_q & mask_done;
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      in_meta_q <= 1'b0;
      in_sync_q <= 1'b0;
      in_prev_q <= 1'b0;
      fb_meta_q <= 1'b0;
      fb_sync_q <= 1'b0;
      fb_prev_q <= 1'b0;
      mask_q    <= 2'd0;
      s_in_q    <= 1'b0;
      s_fb_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, giving a true shift chain regardless of order.
      in_meta_q <= in_meta_d;
      in_sync_q <= in_sync_d;
      in_prev_q <= in_prev_d;
      fb_meta_q <= fb_meta_d;
      fb_sync_q <= fb_sync_d;
      fb_prev_q <= fb_prev_d;
      mask_q    <= mask_d;
      s_in_q    <= s_in_d;
      s_fb_q    <= s_fb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [CW-1:0]             count_q, count_d, count_sat;
  logic signed [WIDTH-1:0]   err_q, err_d;
  logic                      valid_q, valid_d;
  logic                      slip_q, slip_d;
  logic                      up_q, up_d, dn_q, dn_d;

  // count+1 saturated: both the per-cycle increment and the emitted magnitude.
  assign count_sat = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave it
    // unassigned and infer a latch.
    state_d = state_q;
    count_d = count_sat;
    err_d   = err_q;
    valid_d = 1'b0;
    slip_d  = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (s_in_q && s_fb_q) begin
          err_d   = '0;
          valid_d = 1'b1;
        end else if (s_in_q) begin
          state_d = LEAD_IN;
        end else if (s_fb_q) begin
          state_d = LEAD_FB;
        end
      end

      LEAD_IN: begin
        if (s_fb_q) begin
          err_d   = $signed({1'b0, count_sat});
          valid_d = 1'b1;
          count_d = '0;
          // A fresh IN edge in the same cycle immediately opens the next one.
          if (!s_in_q) state_d = IDLE;
        end else if (s_in_q) begin
          err_d   = ERR_MAX;
          valid_d = 1'b1;
          slip_d  = 1'b1;
          count_d = '0;
        end
      end

      LEAD_FB: begin
        if (s_in_q) begin
          err_d   = -$signed({1'b0, count_sat});
          valid_d = 1'b1;
          count_d = '0;
          if (!s_fb_q) state_d = IDLE;
        end else if (s_fb_q) begin
          err_d   = ERR_NEG;
          valid_d = 1'b1;
          slip_d  = 1'b1;
          count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    up_d = (state_d == LEAD_IN);
    dn_d = (state_d == LEAD_FB);
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      slip_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      slip_q  <= slip_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  assign UP        = up_q;
  assign DN        = dn_q;
  assign PHASE_ERR = err_q;
  assign ERR_VALID = valid_q;
  assign SLIP      = slip_q;

  // ---------------------------------------------------------------------------
  // Optional lock detector, fed from the registered measurement outputs so
  // LOCK follows ERR_VALID by one CLK.
  // ---------------------------------------------------------------------------
`ifdef PFD_LOCK_DET_EN
  localparam int               LCW      = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CNT);
  localparam logic [WIDTH-1:0] TOL      = WIDTH'(LOCK_TOL);

  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] err_mag;

  always_comb begin
    // Magnitude cannot overflow: the most negative code is never emitted.
    err_mag    = err_q[WIDTH-1] ? $unsigned(-err_q) : $unsigned(err_q);
    lock_cnt_d = lock_cnt_q;
    if (valid_q) begin
      if ((err_mag <= TOL) && !slip_q) begin
        lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
      end else begin
        lock_cnt_d = '0;
      end
    end
    lock_d = (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign LOCK = lock_q;
`else
  assign LOCK = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_counter.sv
// -----------------------------------------------------------------------------
// tb_pfd_counter -- self-checking bench for pfd_counter (WIDTH=8, CLK 4 ns).
//
// IN/FB change only on the falling CLK edge, so the rising edge that first
// samples a change is unambiguous. The reference model works on those sample
// edges: a measurement is the distance in edges between the IN and FB rises,
// and the DUT shows the result a fixed three CLK later. A directed section
// pins the model with hand-computed values, then random toggling exercises
// everything else against the model on every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pfd_counter;

  localparam int WIDTH    = 8;
  localparam int ERR_MAX  = 127;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_CNT = 16;
`ifdef PFD_LOCK_DET_EN
  localparam bit LOCK_ON  = 1'b1;
`else
  localparam bit LOCK_ON  = 1'b0;
`endif

  logic                    CLK     = 1'b0;
  logic                    RESET_B = 1'b0;
  logic                    IN      = 1'b0;
  logic                    FB      = 1'b0;
  logic                    UP, DN, ERR_VALID, SLIP, LOCK;
  logic signed [WIDTH-1:0] PHASE_ERR;

  always #2 CLK = ~CLK;

  pfd_counter #(.WIDTH(WIDTH), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)) dut (
    .CLK       (CLK),
    .RESET_B   (RESET_B),
    .IN        (IN),
    .FB        (FB),
    .UP        (UP),
    .DN        (DN),
    .PHASE_ERR (PHASE_ERR),
    .ERR_VALID (ERR_VALID),
    .SLIP      (SLIP),
    .LOCK      (LOCK)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (per sample edge) and per-cycle comparison
  // ---------------------------------------------------------------------------
  typedef struct {
    bit up;
    bit dn;
    bit valid;
    bit slip;
    int err;
    bit lock;
  } exp_t;

  exp_t pipe [5];   // pipe[i] = model result i sample edges ago
  int   edge_n, leader, start_e, m_err, m_lock_cnt;
  bit   prev_in, prev_fb, r_in, r_fb, cur_valid, cur_slip, m_lock;

  // Observations taken from the DUT for the directed checks.
  int obs_valid, obs_slip, obs_err, obs_slip_err, up_run, dn_run, up_max, dn_max;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int abs_i(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic void m_emit(input int v, input bit s);
    m_err     = v;
    cur_valid = 1'b1;
    cur_slip  = s;
    if (LOCK_ON) begin
      if (abs_i(v) <= LOCK_TOL && !s) m_lock_cnt = min_i(m_lock_cnt + 1, LOCK_CNT);
      else                            m_lock_cnt = 0;
      m_lock = (m_lock_cnt == LOCK_CNT);
    end else begin
      m_lock = 1'b0;
    end
  endfunction

  always @(posedge CLK) begin
    if (!RESET_B) begin
      edge_n = 0; leader = 0; start_e = 0; m_err = 0; m_lock_cnt = 0;
      prev_in = 1'b0; prev_fb = 1'b0; m_lock = 1'b0;
      for (int i = 0; i < 5; i++) pipe[i] = '{default: 0};
    end else begin
      edge_n++;
      // Rises seen on the first sample edge after release are ignored.
      r_in    = IN && !prev_in && (edge_n >= 2);
      r_fb    = FB && !prev_fb && (edge_n >= 2);
      prev_in = IN;
      prev_fb = FB;
      cur_valid = 1'b0;
      cur_slip  = 1'b0;
      case (leader)
        0: begin
          if (r_in && r_fb) m_emit(0, 1'b0);
          else if (r_in) begin leader = 1; start_e = edge_n; end
          else if (r_fb) begin leader = 2; start_e = edge_n; end
        end
        1: begin
          if (r_fb) begin
            m_emit(min_i(edge_n - start_e, ERR_MAX), 1'b0);
            if (r_in) start_e = edge_n; else leader = 0;
          end else if (r_in) begin
            m_emit(ERR_MAX, 1'b1);
            start_e = edge_n;
          end
        end
        default: begin
          if (r_in) begin
            m_emit(-min_i(edge_n - start_e, ERR_MAX), 1'b0);
            if (r_fb) start_e = edge_n; else leader = 0;
          end else if (r_fb) begin
            m_emit(-ERR_MAX, 1'b1);
            start_e = edge_n;
          end
        end
      endcase
      for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{up: (leader == 1), dn: (leader == 2), valid: cur_valid,
                  slip: cur_slip, err: m_err, lock: m_lock};

      #1;
      if (RESET_B) begin
        check("up",        int'(UP),        int'(pipe[3].up));
        check("dn",        int'(DN),        int'(pipe[3].dn));
        check("err_valid", int'(ERR_VALID), int'(pipe[3].valid));
        check("slip",      int'(SLIP),      int'(pipe[3].slip));
        check("phase_err", int'(PHASE_ERR), pipe[3].err);
        check("lock",      int'(LOCK),      int'(pipe[4].lock));
        if (ERR_VALID) begin obs_valid++; obs_err = int'(PHASE_ERR); end
        if (SLIP)      begin obs_slip++;  obs_slip_err = int'(PHASE_ERR); end
        up_run = UP ? up_run + 1 : 0;
        dn_run = DN ? dn_run + 1 : 0;
        if (up_run > up_max) up_max = up_run;
        if (dn_run > dn_max) dn_max = dn_run;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_obs();
    obs_valid = 0; obs_slip = 0; obs_err = 0; obs_slip_err = 0;
    up_run = 0; dn_run = 0; up_max = 0; dn_max = 0;
  endtask

  // One reference/feedback period; d > 0: IN leads by d CLK, d < 0: FB leads.
  task automatic pair(input int d);
    @(negedge CLK);
    if (d > 0) begin
      IN = 1'b1; wait_n(d); FB = 1'b1;
    end else if (d < 0) begin
      FB = 1'b1; wait_n(-d); IN = 1'b1;
    end else begin
      IN = 1'b1; FB = 1'b1;
    end
    wait_n(10);
    IN = 1'b0; FB = 1'b0;
    wait_n(12);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    clear_obs();
    wait_n(3);
    #1;
    check("rst_up",        int'(UP),        0);
    check("rst_dn",        int'(DN),        0);
    check("rst_err_valid", int'(ERR_VALID), 0);
    check("rst_phase_err", int'(PHASE_ERR), 0);
    check("rst_lock",      int'(LOCK),      0);
    @(negedge CLK);
    RESET_B = 1'b1;
    wait_n(5);

    // IN leads by 12 ns = 3 CLK.
    clear_obs();
    repeat (3) pair(3);
    check("lead_in_err",    obs_err,   3);
    check("lead_in_count",  obs_valid, 3);
    check("lead_in_up_len", up_max,    3);
    check("lead_in_dn_len", dn_max,    0);

    // FB leads by 8 ns = 2 CLK.
    clear_obs();
    repeat (3) pair(-2);
    check("lead_fb_err",    obs_err, -2);
    check("lead_fb_dn_len", dn_max,   2);
    check("lead_fb_up_len", up_max,   0);

    // Simultaneous rises.
    clear_obs();
    repeat (3) pair(0);
    check("coinc_err",    obs_err,   0);
    check("coinc_count",  obs_valid, 3);
    check("coinc_up_len", up_max,    0);
    check("coinc_dn_len", dn_max,    0);

    // Two IN rises without FB -> slip, then FB late -> saturated count.
    clear_obs();
    @(negedge CLK); IN = 1'b1; wait_n(4); IN = 1'b0; wait_n(20);
    IN = 1'b1; wait_n(4); IN = 1'b0; wait_n(20);
    check("slip_count", obs_slip,     1);
    check("slip_err",   obs_slip_err, 127);
    wait_n(150);
    FB = 1'b1; wait_n(10); FB = 1'b0; wait_n(10);
    check("sat_pos_err",   obs_err,   127);
    check("sat_pos_count", obs_valid, 2);
    check("sat_pos_dn",    dn_max,    0);

    // FB held ahead for 600 ns -> negative saturation, no slip.
    clear_obs();
    @(negedge CLK); FB = 1'b1; wait_n(150);
    IN = 1'b1; wait_n(10); IN = 1'b0; FB = 1'b0; wait_n(10);
    check("sat_neg_err",  obs_err,  -127);
    check("sat_neg_slip", obs_slip, 0);

    // Lock: 16+ consecutive small errors, then one large error.
    repeat (17) pair(1);
    check("lock_set", int'(LOCK), int'(LOCK_ON));
    clear_obs();
    pair(5);
    check("lock_break_err", obs_err,    5);
    check("lock_clear",     int'(LOCK), 0);

    // Reset in the middle of a LEAD_IN measurement, IN still high at release.
    @(negedge CLK); IN = 1'b1;
    wait_n(6);
    check("mid_up_before", int'(UP), 1);
    RESET_B = 1'b0;
    #1;
    check("mid_rst_up",        int'(UP),        0);
    check("mid_rst_err_valid", int'(ERR_VALID), 0);
    check("mid_rst_phase_err", int'(PHASE_ERR), 0);
    check("mid_rst_slip",      int'(SLIP),      0);
    wait_n(3);
    RESET_B = 1'b1;
    clear_obs();
    wait_n(20);
    check("mid_rel_valid", obs_valid, 0);
    check("mid_rel_up",    up_max,    0);
    IN = 1'b0;
    wait_n(10);

    // Random toggling of both clocks, checked every cycle by the model.
    repeat (3000) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) IN = ~IN;
      if ($urandom_range(7) == 0) FB = ~FB;
    end
    IN = 1'b0; FB = 1'b0;
    wait_n(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
